// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory req/ack, decode-side valid/ready and branch redirect.
// Optional perf counter outputs appear when FETCH_PERF_EN is defined.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] Instr;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        PCSrc;
    logic [31:0] PCTarget;
    logic        fetch_fault;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    modport master (
        output imem_req, imem_addr, instr_valid, Instr, PC, PCPlus4, fetch_fault,
`ifdef FETCH_PERF_EN
        output perf_fetched, perf_stall,
`endif
        input  imem_ack, imem_rdata, instr_ready, PCSrc, PCTarget
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, Instr, PC, PCPlus4, fetch_fault,
`ifdef FETCH_PERF_EN
        input  perf_fetched, perf_stall,
`endif
        output imem_ack, imem_rdata, instr_ready, PCSrc, PCTarget
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns PC, fetches one word per req/ack, holds it for decode.
// Optional macro FETCH_PERF_EN adds perf_fetched / perf_stall counters.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 8;
    localparam logic [XLEN-1:0]  NOP_INSTR = 32'h0000_0013;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_HOLD  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t            r_state;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_pc_plus4;
    logic [XLEN-1:0]   r_instr;
    logic              r_valid;
    logic              r_req;
    logic              r_fault;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_ack;
    logic              w_accept;
    logic              w_misaligned;
    logic [XLEN-1:0]   w_next_pc;

    // Handshake qualifiers: ack only counts in REQ, redirect only on accept.
    assign w_ack        = (r_state == S_REQ) && bus.imem_ack;
    assign w_accept     = (r_state == S_HOLD) && bus.instr_ready;
    assign w_misaligned = bus.PCSrc && (bus.PCTarget[1:0] != 2'b00);
    assign w_next_pc    = bus.PCSrc ? bus.PCTarget : r_pc_plus4;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_pc_plus4 <= RESET_PC + XLEN'(4);
            r_instr    <= NOP_INSTR;
            r_valid    <= 1'b0;
            r_req      <= 1'b0;
            r_fault    <= 1'b0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_REQ;
                    r_req   <= 1'b1;
                    r_cnt   <= '0;
                end
                S_REQ: begin
                    if (w_ack) begin
                        r_instr <= bus.imem_rdata;
                        r_valid <= 1'b1;
                        r_req   <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_HOLD;
                    end else if (r_cnt == CNT_LAST) begin
                        r_req   <= 1'b0;
                        r_fault <= 1'b1;
                        r_state <= S_FAULT;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (w_accept) begin
                        r_valid <= 1'b0;
                        // Misaligned redirect faults and leaves PC untouched.
                        if (w_misaligned) begin
                            r_fault <= 1'b1;
                            r_state <= S_FAULT;
                        end else begin
                            r_pc       <= w_next_pc;
                            r_pc_plus4 <= w_next_pc + XLEN'(4);
                            r_req      <= 1'b1;
                            r_cnt      <= '0;
                            r_state    <= S_REQ;
                        end
                    end
                end
                S_FAULT: begin
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                    r_fault <= 1'b1;
                end
                default: begin
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                    r_fault <= 1'b1;
                    r_state <= S_FAULT;
                end
            endcase
        end
    end

    assign bus.imem_req    = r_req;
    assign bus.imem_addr   = r_pc;
    assign bus.instr_valid = r_valid;
    assign bus.Instr       = r_instr;
    assign bus.PC          = r_pc;
    assign bus.PCPlus4     = r_pc_plus4;
    assign bus.fetch_fault = r_fault;

`ifdef FETCH_PERF_EN
    logic [XLEN-1:0] r_perf_fetched;
    logic [XLEN-1:0] r_perf_stall;
    logic            w_stall;

    // A stall is a REQ cycle without ack or a HOLD cycle the consumer refuses.
    assign w_stall = ((r_state == S_REQ)  && !bus.imem_ack) ||
                     ((r_state == S_HOLD) && !bus.instr_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_fetched <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (w_accept) r_perf_fetched <= r_perf_fetched + XLEN'(1);
            if (w_stall)  r_perf_stall   <= r_perf_stall + XLEN'(1);
        end
    end

    assign bus.perf_fetched = r_perf_fetched;
    assign bus.perf_stall   = r_perf_stall;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: scoreboard of issued memory words vs. presented instructions.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_accept = 0;
    logic [31:0] exp_pc;
    exp_t        sb[$];

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(RESET_PC), .TIMEOUT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"},     32'(bus.imem_req), 32'd0);
        chk({tag, "_valid"},   32'(bus.instr_valid), 32'd0);
        chk({tag, "_fault"},   32'(bus.fetch_fault), 32'd0);
        chk({tag, "_instr"},   bus.Instr, NOP);
        chk({tag, "_pc"},      bus.PC, RESET_PC);
        chk({tag, "_pcplus4"}, bus.PCPlus4, RESET_PC + 32'd4);
    endtask

    // Called at #1 after REQ entry: acks in the first REQ cycle and checks the HOLD result.
    task automatic fetch(input logic [31:0] word);
        exp_t e;
        chk("req_before_ack", 32'(bus.imem_req), 32'd1);
        chk("imem_addr", bus.imem_addr, exp_pc);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = word;
        sb.push_back('{exp_pc, word});
        step();
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        chk("instr_valid", 32'(bus.instr_valid), 32'd1);
        chk("req_in_hold", 32'(bus.imem_req), 32'd0);
        chk("sb_depth", 32'(sb.size()), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("Instr", bus.Instr, e.instr);
            chk("PC", bus.PC, e.pc);
            chk("PCPlus4", bus.PCPlus4, e.pc + 32'd4);
        end
    endtask

    task automatic accept(input logic src, input logic [31:0] tgt);
        bus.instr_ready = 1'b1;
        bus.PCSrc       = src;
        bus.PCTarget    = tgt;
        step();
        bus.instr_ready = 1'b0;
        bus.PCSrc       = 1'b0;
        bus.PCTarget    = '0;
        n_accept++;
        if (!(src && tgt[1:0] != 2'b00)) exp_pc = src ? tgt : exp_pc + 32'd4;
    endtask

    task automatic do_reset(input string tag);
        bus.imem_ack = 1'b0;
        reset = 1'b1;
        #1;
        chk_reset(tag);
        step();
        reset    = 1'b0;
        n_accept = 0;
        exp_pc   = RESET_PC;
        step();
    endtask

    initial begin
        reset           = 1'b1;
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = '0;
        bus.instr_ready = 1'b0;
        bus.PCSrc       = 1'b0;
        bus.PCTarget    = '0;
        exp_pc          = RESET_PC;
        repeat (2) step();
        chk_reset("por");

        // First fetch: req one cycle after release, same-cycle ack.
        reset = 1'b0;
        step();
        fetch(32'h0050_0093);
        accept(1'b0, '0);
        fetch(32'h00A0_0113);

        // Backpressure; stray ack and redirect inputs must be ignored.
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hBADC_0DE0;
        bus.PCSrc      = 1'b1;
        bus.PCTarget   = 32'h0000_0200;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", 32'(bus.instr_valid), 32'd1);
            chk("bp_req", 32'(bus.imem_req), 32'd0);
            chk("bp_instr", bus.Instr, 32'h00A0_0113);
            chk("bp_pc", bus.PC, 32'h0000_0004);
        end
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        accept(1'b0, '0);
        fetch(32'h0020_8193);

        // Aligned redirect, then misaligned redirect into FAULT.
        accept(1'b1, 32'h0000_0100);
        fetch(32'h0000_0513);
        accept(1'b1, 32'h0000_0102);
        chk("mis_fault", 32'(bus.fetch_fault), 32'd1);
        chk("mis_req", 32'(bus.imem_req), 32'd0);
        chk("mis_valid", 32'(bus.instr_valid), 32'd0);
        chk("mis_pc", bus.PC, 32'h0000_0100);
        bus.imem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fault_sticky", 32'(bus.fetch_fault), 32'd1);
            chk("fault_req", 32'(bus.imem_req), 32'd0);
        end
        do_reset("rst_after_mis");

        // Timeout: 16 REQ cycles without ack.
        for (int i = 0; i < 15; i++) begin
            step();
            chk("to_waiting_fault", 32'(bus.fetch_fault), 32'd0);
            chk("to_waiting_req", 32'(bus.imem_req), 32'd1);
            chk("to_addr_stable", bus.imem_addr, RESET_PC);
        end
        step();
        chk("to_fault", 32'(bus.fetch_fault), 32'd1);
        chk("to_req", 32'(bus.imem_req), 32'd0);
        repeat (4) step();
        chk("to_sticky", 32'(bus.fetch_fault), 32'd1);
        do_reset("rst_after_to");

        // Async reset mid-REQ with a simultaneous ack: data must be dropped.
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        #2;
        reset = 1'b1;
        #1;
        chk_reset("mid_req");
        step();
        chk_reset("mid_req_held");
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        reset          = 1'b0;
        n_accept       = 0;
        exp_pc         = RESET_PC;
        step();
        fetch(32'h0000_0033);

        // PC wrap past the top of the address space.
        accept(1'b1, 32'hFFFF_FFFC);
        fetch(32'h0010_0073);
        accept(1'b0, '0);
        chk("wrap_fault", 32'(bus.fetch_fault), 32'd0);
        fetch(32'h0000_0013);
`ifdef FETCH_PERF_EN
        chk("perf_fetched", bus.perf_fetched, 32'(n_accept));
        chk("perf_stall_zero", bus.perf_stall, 32'd0);
        repeat (2) step();
        chk("perf_stall_hold", bus.perf_stall, 32'd2);
`endif
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1);
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the immediate extender and decoder.
- Owns the PC register and a req/ack handshake to instruction memory.
- Presents a registered instruction word (Instr) with valid/ready to decode/extend.
- Takes branch redirects (PCSrc/PCTarget) from the execute side.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- TIMEOUT, 16, maximum cycles in REQ without imem_ack before fetch_fault; legal range 2..255.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- imem_req  output  1  fetch request; high only in state REQ.
- imem_addr  output  32  word address; equals PC.
- imem_ack  input  1  memory returns imem_rdata this cycle; sampled only while imem_req=1.
- imem_rdata  input  32  instruction word, valid when imem_ack=1.
- instr_valid  output  1  Instr/PC/PCPlus4 are valid.
- instr_ready  input  1  consumer accepts the instruction.
- Instr  output  32  registered instruction to decode/extend.
- PC  output  32  address of Instr.
- PCPlus4  output  32  PC + 4, modulo 2^32.
- PCSrc  input  1  redirect select, sampled on accept.
- PCTarget  input  32  redirect target, sampled on accept.
- fetch_fault  output  1  sticky fault flag.

Behaviour:
- Reset (async, any state, mid-handshake included) sets:
  - state=IDLE, PC=RESET_PC, Instr=32'h00000013 (NOP), instr_valid=0, imem_req=0, fetch_fault=0, timeout counter=0.
  - Any in-flight ack is discarded.
- States are IDLE, REQ, HOLD and FAULT. All registered outputs update on the rising clk edge.
- IDLE: exactly one cycle after reset release, then REQ.
- REQ:
  - imem_req=1, imem_addr=PC; address held stable until ack.
  - On imem_ack=1: Instr<=imem_rdata, instr_valid<=1, counter<=0, go to HOLD. An ack in the first REQ cycle is legal.
  - On no ack: counter increments. When counter reaches TIMEOUT-1 without ack, go to FAULT at the next edge.
- HOLD:
  - instr_valid=1; Instr and PC held stable while instr_ready=0.
  - On instr_ready=1 (accept): PC <= PCSrc ? PCTarget : PCPlus4; instr_valid<=0; go to REQ.
  - Minimum latency from REQ entry with same-cycle ack to instr_valid is 1 cycle. Peak throughput is one instruction per 2 cycles.
- Misaligned redirect: accept with PCSrc=1 and PCTarget[1:0]!=0 goes to FAULT; PC is not updated.
- PCPlus4 wraps: PC=32'hFFFFFFFC gives PCPlus4=32'h00000000, no fault.
- FAULT:
  - fetch_fault=1, imem_req=0, instr_valid=0.
  - Only reset exits this state.
- PCSrc/PCTarget are ignored outside an accept cycle.
- imem_ack outside REQ is ignored.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - Adds output perf_fetched (32) and output perf_stall (32), both reset to 0 and wrapping modulo 2^32.
  - perf_fetched increments on each accept.
  - perf_stall increments on each REQ cycle without ack, and on each HOLD cycle with instr_ready=0.
- Undefined: the ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset release with RESET_PC=0, memory acking in the first REQ cycle with rdata=32'h00500093, instr_ready=1 → imem_req high 1 cycle after release, imem_addr=0; next cycle instr_valid=1, Instr=32'h00500093, PC=0, PCPlus4=4; next fetch has addr=4.
- Backpressure: instr_ready=0 for 5 cycles in HOLD → Instr/PC stable, no imem_req; ready=1 → REQ for addr PC+4.
- Redirect: accept with PCSrc=1, PCTarget=32'h00000100 → next imem_addr=32'h100. Second redirect to 32'h102 → fetch_fault=1 next cycle, imem_req stays 0.
- Timeout: never ack, TIMEOUT=16 → fetch_fault asserts after 16 REQ cycles; only reset clears it; PC returns to RESET_PC.
- Async reset asserted mid-REQ, with ack arriving in the same cycle → outputs go to reset values immediately; Instr=32'h00000013; ack data never appears.
- Wrap: PC=32'hFFFFFFFC, PCSrc=0 accept → next imem_addr=0, no fault. With FETCH_PERF_EN: perf_fetched equals the accept count.
